pulse_stretch: RTL and testbench

PULSE_STRETCH -- requirements
Module: pulse_stretch

---
 rtl/pulse_stretch_pkg.sv | 12 +
 rtl/edgepos.sv | 28 ++
 rtl/pulse_stretch.sv | 106 ++++++++++
 tb/tb_pulse_stretch.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared types and defaults for the pulse stretcher.
// Contents: state enumeration (IDLE, ACTIVE) and the default length-counter width.
package pulse_stretch_pkg;

    localparam int unsigned LEN_W_DEFAULT = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/edgepos.sv
// Rising-edge detector: flags a cycle where d is high and its registered copy is low.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset; the delayed copy resets to 1 so a
//            level already high at reset release is not seen as an edge
//   d      - level input, synchronous to clk
//   rise_c - combinational rising-edge flag (d & ~d_z)
module edgepos (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_c
);

    logic d_z;

    // Delayed copy of the input level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_z <= 1'b1;
        end else begin
            d_z <= d;
        end
    end

    assign rise_c = d & ~d_z;

endmodule

// File: rtl/pulse_stretch.sv
// Pulse stretcher: a rising edge on din produces a dout pulse of len clk cycles.
// Build option: PULSE_STRETCH_RETRIGGER_EN
//   defined   - a trigger during a pulse (len != 0) restarts the length count
//   undefined - a trigger during a pulse is dropped and flagged on overrun
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset
//   din     - trigger level; its rising edge starts a pulse
//   len     - pulse length in cycles, sampled on the trigger cycle only
//   dout    - stretched pulse (state register)
//   busy    - pulse in progress, identical to dout
//   done    - one-cycle strobe after the last pulse cycle
//   overrun - one-cycle strobe after a dropped trigger
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [LEN_W-1:0] len,
    output logic             dout,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    state_e           state;
    state_e           state_d;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_d;
    logic             done_d;
    logic             overrun_d;
    logic             trig_c;
    logic             len_nz_c;

    edgepos u_edge (
        .clk    (clk),
        .rst    (rst),
        .d      (din),
        .rise_c (trig_c)
    );

    assign len_nz_c = (len != '0);

    // State, counter and strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            done    <= done_d;
            overrun <= overrun_d;
        end
    end

    // Next-state, counter and strobe logic
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        case (state)
            IDLE: begin
                // A zero-length trigger is discarded silently
                if (trig_c && len_nz_c) begin
                    state_d = ACTIVE;
                    cnt_d   = len - LEN_W'(1);
                end
            end
            ACTIVE: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                if (trig_c && len_nz_c) begin
                    cnt_d = len - LEN_W'(1);
                end else if (cnt != '0) begin
                    cnt_d = cnt - LEN_W'(1);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`else
                if (cnt != '0) begin
                    cnt_d = cnt - LEN_W'(1);
                end else begin
                    state_d = IDLE;
                    // overrun takes precedence so the two strobes never coincide
                    done_d  = ~trig_c;
                end
                overrun_d = trig_c;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout = (state == ACTIVE);
    assign busy = dout;

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch: per-cycle expected outputs are pushed
// to a scoreboard queue as stimulus is driven and popped at mid-cycle.
module tb_pulse_stretch;

    localparam int unsigned LW = 8;

    typedef struct packed {
        logic dout;
        logic busy;
        logic done;
        logic overrun;
    } obs_t;

    logic          clk;
    logic          rst;
    logic          din;
    logic [LW-1:0] len;
    logic          dout;
    logic          busy;
    logic          done;
    logic          overrun;

    int   checks;
    int   failures;
    obs_t exp_q[$];
    obs_t got;
    obs_t exp;

    pulse_stretch #(.LEN_W(LW)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .len     (len),
        .dout    (dout),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic d, input logic dn, input logic ov);
        return obs_t'({d, d, dn, ov});
    endfunction

    // Drive one cycle of stimulus, queue its expected outputs, and stop mid-cycle
    task automatic drive(input logic d, input logic [LW-1:0] l, input obs_t e);
        @(posedge clk);
        #1;
        din = d;
        len = l;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        din = 1'b0;
        len = '0;
        #1;
        got = {dout, busy, done, overrun};
        checks++;
        if (got !== 4'b0000) begin
            failures++;
            $display("FAIL reset_immediate got=%b exp=0000", got);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {dout, busy, done, overrun};
        checks++;
        if (got !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held got=%b exp=0000", got);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        for (int c = 0; c < 35; c++) begin
            drive(c >= 10 && c < 30, LW'(3), mk(c >= 11 && c <= 13, c == 14, 1'b0));
            got = {dout, busy, done, overrun};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL basic cyc=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_zero_len;
        for (int c = 0; c < 12; c++) begin
            drive(c == 5, LW'(0), mk(1'b0, 1'b0, 1'b0));
            got = {dout, busy, done, overrun};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL zero_len cyc=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_max_len;
        for (int c = 0; c < 262; c++) begin
            drive(c == 2, LW'(255), mk(c >= 3 && c <= 257, c == 258, 1'b0));
            got = {dout, busy, done, overrun};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL max_len cyc=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        obs_t e;
        for (int c = 0; c < 22; c++) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
            e = mk(c >= 11 && c <= 16, c == 17, 1'b0);
`else
            e = mk(c >= 11 && c <= 15, c == 16, c == 13);
`endif
            drive(c == 10 || c == 12, (c <= 10) ? LW'(5) : LW'(4), e);
            got = {dout, busy, done, overrun};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_last_cycle;
        obs_t e;
        for (int c = 0; c < 22; c++) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
            e = mk(c >= 11 && c <= 16, c == 17, 1'b0);
`else
            e = mk(c >= 11 && c <= 13, 1'b0, c == 14);
`endif
            drive(c == 10 || c == 13, LW'(3), e);
            got = {dout, busy, done, overrun};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL last_cycle cyc=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_reset_abort;
        for (int c = 0; c < 14; c++) begin
            drive(c >= 10, LW'(6), mk(c >= 11, 1'b0, 1'b0));
            got = {dout, busy, done, overrun};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL abort_pre cyc=%0d got=%b exp=%b", c, got, exp);
            end
        end
        // Mid-cycle asynchronous reset while the pulse is active
        #2;
        rst = 1'b1;
        #1;
        got = {dout, busy, done, overrun};
        checks++;
        if (got !== 4'b0000) begin
            failures++;
            $display("FAIL abort_immediate got=%b exp=0000", got);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // din stays high through release: no pulse, no done
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, LW'(6), mk(1'b0, 1'b0, 1'b0));
            got = {dout, busy, done, overrun};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL abort_post cyc=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_zero_len();
        test_max_len();
        test_back_to_back();
        test_last_cycle();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
